// File: rtl/reg_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_ctrl_if
// Brief    : CPU-side, register-file and dump-stream signals of reg_dump_ctrl.
// Revision : 1.0
// ============================================================================
interface reg_dump_ctrl_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_stall;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        resume;
    logic        done;
    logic        timeout;

    // master: the dump controller; slave: the CPU/sink environment
    modport master (
        input  pc, instr, bp_en, bp_addr, reg_data, dump_ready, resume,
        output cpu_stall, reg_sel, dump_valid, dump_data, dump_last, done, timeout
    );

    modport slave (
        output pc, instr, bp_en, bp_addr, reg_data, dump_ready, resume,
        input  cpu_stall, reg_sel, dump_valid, dump_data, dump_last, done, timeout
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_ctrl
// Brief    : Halts the CPU on breakpoint or idle-cycle limit and streams
//            pc, instr and r0..r31 out as a 34-word valid/ready dump.
// Revision : 1.0
// ============================================================================
module reg_dump_ctrl #(
    parameter int unsigned CYCLE_LIMIT = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_dump_ctrl_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] c_limit_m1  = 16'(CYCLE_LIMIT - 1);
    localparam logic [5:0]  c_last_idx  = 6'd33;
    localparam logic [5:0]  c_num_words = 6'd34;

    state_t      state_q,      state_d;
    logic [15:0] cnt_q,        cnt_d;
    logic [5:0]  idx_q,        idx_d;
    logic [31:0] snap_pc_q,    snap_pc_d;
    logic [31:0] snap_instr_q, snap_instr_d;
    logic [31:0] data_q,       data_d;
    logic        valid_q,      valid_d;
    logic        last_q,       last_d;
    logic        timeout_q,    timeout_d;

    logic        w_bp_hit;
    logic        w_lim_hit;
    logic        w_trigger;
    logic        w_load;
    logic [31:0] w_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_pc_q    <= '0;
            snap_instr_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_pc_q    <= snap_pc_d;
            snap_instr_q <= snap_instr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        w_bp_hit  = bus.bp_en && (bus.pc == bus.bp_addr);
        w_lim_hit = (cnt_q == c_limit_m1);
        w_trigger = (state_q == ST_IDLE) && (w_bp_hit || w_lim_hit);
        // The output register may take a new word when empty or being drained.
        w_load    = !valid_q || bus.dump_ready;

        case (idx_q)
            6'd0:    w_word = snap_pc_q;
            6'd1:    w_word = snap_instr_q;
            6'd2:    w_word = 32'h0000_0000;
            default: w_word = bus.reg_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_pc_d    = snap_pc_q;
        snap_instr_d = snap_instr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (w_trigger) begin
                    snap_pc_d    = bus.pc;
                    snap_instr_d = bus.instr;
                    timeout_d    = !w_bp_hit;
                    state_d      = ST_HALT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HALT: begin
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (idx_q < c_num_words) begin
                    if (w_load) begin
                        data_d  = w_word;
                        last_d  = (idx_q == c_last_idx);
                        valid_d = 1'b1;
                        idx_d   = idx_q + 6'd1;
                    end
                end else if (valid_q && bus.dump_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.resume) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Indices 32 and 33 wrap in 5 bits to r30 and r31.
    assign bus.reg_sel    = ((idx_q >= 6'd2) && (idx_q <= c_last_idx)) ? (idx_q[4:0] - 5'd2) : 5'd0;
    assign bus.cpu_stall  = w_trigger || (state_q != ST_IDLE);
    assign bus.dump_valid = valid_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_last  = last_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.timeout    = timeout_q;

endmodule
`default_nettype wire
